// File: rtl/baud_tick_gen.sv
// Programmable oversampling/baud tick generator with fractional divisor,
// handshaked runtime reconfiguration and RX phase re-alignment.
module baud_tick_gen #(
  parameter int DIV_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int OSR     = 16,
  parameter int DEF_DIV = 27,
  parameter int PH_W    = $clog2(OSR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_ready,
  input  logic              resync,
  output logic              sample_tick,
  output logic              baud_tick,
  output logic [PH_W-1:0]   sample_phase,
  output logic              clk_sampling,
  output logic              clk_uart
);

  localparam logic [DIV_W-1:0] DEF_DIV_L = DIV_W'(DEF_DIV);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]  PH_HALF   = PH_W'(OSR / 2);

  logic [DIV_W-1:0]  div_r, div_s, cnt;
  logic [FRAC_W-1:0] frac_r, frac_s, acc;
  logic [PH_W-1:0]   phase;
  logic              pend;

  logic              terminal, apply, accept;
  logic [DIV_W-1:0]  div_eff, reload, cfg_div_clamped;
  logic [FRAC_W-1:0] frac_eff, acc_base;
  logic [FRAC_W:0]   acc_sum;
  logic [PH_W-1:0]   phase_inc;

  assign cfg_ready    = ~pend;
  assign sample_phase = phase;

  // A pending divisor is swapped in on the terminal cycle itself (or at once
  // while counting is paused), so the reload below already sees the new value.
  always_comb begin
    terminal        = en && !resync && (cnt == '0);
    apply           = pend && (terminal || !en);
    accept          = cfg_valid && !pend;
    cfg_div_clamped = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    div_eff         = apply ? div_s  : div_r;
    frac_eff        = apply ? frac_s : frac_r;
    acc_base        = apply ? '0     : acc;
    acc_sum         = {1'b0, acc_base} + {1'b0, frac_eff};
    reload          = div_eff - DIV_W'(1) + DIV_W'(acc_sum[FRAC_W]);
    phase_inc       = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_r        <= DEF_DIV_L;
      frac_r       <= '0;
      div_s        <= DEF_DIV_L;
      frac_s       <= '0;
      cnt          <= '0;
      acc          <= '0;
      phase        <= '0;
      pend         <= 1'b0;
      sample_tick  <= 1'b0;
      baud_tick    <= 1'b0;
      clk_sampling <= 1'b0;
      clk_uart     <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      baud_tick   <= 1'b0;

      if (accept) begin
        div_s  <= cfg_div_clamped;
        frac_s <= cfg_frac;
        pend   <= 1'b1;
      end

      if (apply) begin
        div_r  <= div_s;
        frac_r <= frac_s;
        pend   <= 1'b0;
      end

      // Resync restarts the sample period without emitting a tick.
      if (en) begin
        if (resync) begin
          cnt      <= div_r - DIV_W'(1);
          acc      <= '0;
          phase    <= '0;
          clk_uart <= 1'b1;
        end else if (cnt == '0) begin
          sample_tick  <= 1'b1;
          baud_tick    <= (phase == PH_LAST);
          acc          <= acc_sum[FRAC_W-1:0];
          cnt          <= reload;
          phase        <= phase_inc;
          clk_sampling <= ~clk_sampling;
          clk_uart     <= (phase_inc < PH_HALF);
        end else begin
          cnt <= cnt - DIV_W'(1);
        end
      end else if (apply) begin
        acc <= '0;
      end
    end
  end

endmodule
